ap_ctrl_sequencer: RTL and testbench

- Synthesizable initiator for the HLS block-level handshake (ap_start / ap_ready / ap_done / ap_continue).
- Issues a programmed number of transactions to a DUT and tracks accepted starts and completions.
- Raises `finish` when the run completes, and detects hangs and protocol violations.
- Sits between the testbench top or an on-chip test controller and the DUT control port, complementing the passive module-status monitor.

---
 rtl/ap_ctrl_pkg.sv | 16 +
 rtl/ap_ctrl_sequencer_if.sv | 23 ++
 rtl/ap_ctrl_watchdog.sv | 32 +++
 rtl/ap_ctrl_sequencer.sv | 149 ++++++++++++++
 tb/tb_ap_ctrl_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ap_ctrl_pkg.sv
// Shared types and default sizing for the ap_ctrl handshake sequencer.
package ap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } ap_ctrl_state_e;

    localparam int unsigned TXN_W_DEF       = 16;
    localparam int unsigned CYC_W_DEF       = 32;
    localparam int unsigned TIMEOUT_CYC_DEF = 100000;

endpackage

// File: rtl/ap_ctrl_sequencer_if.sv
// HLS block-level control handshake between the sequencer (master) and the DUT (slave).
interface ap_ctrl_sequencer_if;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (
        output ap_start,
        output ap_continue,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        input  ap_continue,
        output ap_ready,
        output ap_done
    );

endinterface

// File: rtl/ap_ctrl_watchdog.sv
// Hang watchdog: reloads on clr or while disabled, counts down while enabled and
// pulses expired on the TIMEOUT_CYC-th consecutive enabled cycle.
module ap_ctrl_watchdog
    import ap_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] LOAD   = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic [WD_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= LOAD;
        end else if (clr || !en) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - WD_ONE;
        end
    end

    assign expired = en && !clr && (cnt == WD_ONE);

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: issues a programmed number of ap_start transactions, counts retired
// dones, and flags hangs and spurious dones. Define AP_CTRL_CHAIN_EN for ap_ctrl_chain backpressure.
module ap_ctrl_sequencer
    import ap_ctrl_pkg::*;
#(
    parameter int unsigned TXN_W       = TXN_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CYC_W       = CYC_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_go,
    input  logic [TXN_W-1:0]    cfg_num_txn,
    ap_ctrl_sequencer_if.master ap,
    input  logic                sink_ready,
    output logic                busy,
    output logic                finish,
    output logic                timeout,
    output logic                proto_err,
    output logic [TXN_W-1:0]    start_cnt,
    output logic [TXN_W-1:0]    done_cnt,
    output logic [CYC_W-1:0]    run_cycles
);
    localparam logic [TXN_W-1:0] TXN_ONE = TXN_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    ap_ctrl_state_e state, state_nx;

    logic [TXN_W-1:0] num_q;
    logic [TXN_W-1:0] start_inc;
    logic [TXN_W-1:0] done_inc;
    logic             cont;
    logic             go_ok;
    logic             active;
    logic             start_acc;
    logic             retire;
    logic             outstanding;
    logic             done_ok;
    logic             spurious;
    logic             wd_exp;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_ONE;
    endfunction

    // A done is only credited against an outstanding start; otherwise it is a protocol error.
    assign go_ok       = cfg_go && (state == ST_IDLE || state == ST_DONE);
    assign active      = (state == ST_RUN) || (state == ST_DRAIN);
    assign start_acc   = (state == ST_RUN) && ap.ap_ready;
    assign retire      = ap.ap_done && cont;
    assign outstanding = start_cnt > done_cnt;
    assign done_ok     = active && retire && outstanding;
    assign spurious    = retire && !outstanding && (state != ST_ERR);
    assign start_inc   = start_cnt + TXN_ONE;
    assign done_inc    = done_cnt + TXN_ONE;

    ap_ctrl_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .en      (active && outstanding),
        .clr     (done_ok),
        .expired (wd_exp)
    );

`ifdef AP_CTRL_CHAIN_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont <= 1'b0;
        end else begin
            cont <= sink_ready;
        end
    end
`else
    logic unused_sink_ready;
    assign unused_sink_ready = sink_ready;
    assign cont              = 1'b1;
`endif

    assign ap.ap_continue = cont;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (cfg_go) begin
                    state_nx = (cfg_num_txn != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (wd_exp) begin
                    state_nx = ST_ERR;
                end else if (start_acc && (start_inc == num_q)) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wd_exp) begin
                    state_nx = ST_ERR;
                end else if (done_ok && (done_inc == num_q)) begin
                    state_nx = ST_DONE;
                end
            end
            ST_ERR:  state_nx = ST_ERR;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        ap.ap_start = (state == ST_RUN);
        busy        = active;
        finish      = (state == ST_DONE);
    end

    // ERR freezes all run bookkeeping until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_q      <= '0;
            start_cnt  <= '0;
            done_cnt   <= '0;
            run_cycles <= '0;
            timeout    <= 1'b0;
            proto_err  <= 1'b0;
        end else if (go_ok) begin
            num_q      <= cfg_num_txn;
            start_cnt  <= '0;
            done_cnt   <= '0;
            run_cycles <= '0;
            timeout    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (start_acc) start_cnt  <= start_inc;
            if (done_ok)   done_cnt   <= done_inc;
            if (active)    run_cycles <= sat_inc(run_cycles);
            if (wd_exp)    timeout    <= 1'b1;
            if (spurious)  proto_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Randomized bench for ap_ctrl_sequencer: an emulated HLS DUT drives ready/done and a
// transaction-level reference model predicts every output each cycle.
`timescale 1ns/1ps
module tb_ap_ctrl_sequencer;

    localparam int TXN_W  = 8;
    localparam int CYC_W  = 6;
    localparam int TMO    = 50;
    localparam int RC_MAX = (1 << CYC_W) - 1;
`ifdef AP_CTRL_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3, P_ERR = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_go = 1'b0;
    logic [TXN_W-1:0] cfg_num_txn = '0;
    logic             sink_ready = 1'b1;
    logic             busy, finish, timeout, proto_err;
    logic [TXN_W-1:0] start_cnt, done_cnt;
    logic [CYC_W-1:0] run_cycles;

    ap_ctrl_sequencer_if bus ();

    ap_ctrl_sequencer #(
        .TXN_W       (TXN_W),
        .TIMEOUT_CYC (TMO),
        .CYC_W       (CYC_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_go      (cfg_go),
        .cfg_num_txn (cfg_num_txn),
        .ap          (bus),
        .sink_ready  (sink_ready),
        .busy        (busy),
        .finish      (finish),
        .timeout     (timeout),
        .proto_err   (proto_err),
        .start_cnt   (start_cnt),
        .done_cnt    (done_cnt),
        .run_cycles  (run_cycles)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    // reference model of the run
    int m_ph, m_n, m_sc, m_dc, m_rc, m_wd;
    bit m_to, m_pe, m_cont;

    // emulated HLS DUT
    int pend[$];
    int cyc = 0, age = 0, st_hi = 0;
    int cap = 1, rdy_dly = 0, rdy_pct = 100, lat_min = 1, lat_max = 1;
    bit rdy_hold = 0, done_en = 1, spur = 0, spur_req = 0, sink_rand = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_n = 0; m_sc = 0; m_dc = 0; m_rc = 0; m_wd = 0;
        m_to = 0; m_pe = 0; m_cont = !CHAIN;
    endtask

    task automatic model_edge();
        bit acc, ret, outst;
        acc = (m_ph == P_RUN) && bus.ap_ready;
        ret = bus.ap_done && m_cont;
        if ((m_ph == P_IDLE || m_ph == P_DONE) && cfg_go) begin
            m_sc = 0; m_dc = 0; m_rc = 0; m_wd = 0; m_to = 0; m_pe = 0;
            m_n  = int'(cfg_num_txn);
            m_ph = (m_n != 0) ? P_RUN : P_DONE;
        end else if (m_ph != P_ERR) begin
            outst = m_sc > m_dc;
            if (ret && !outst) m_pe = 1;
            if (m_ph == P_RUN || m_ph == P_DRAIN) begin
                if (m_rc < RC_MAX) m_rc++;
                if (ret && outst) begin m_dc++; m_wd = 0; end
                else if (outst) m_wd++;
                else m_wd = 0;
                if (acc) m_sc++;
                if (m_wd >= TMO) begin m_ph = P_ERR; m_to = 1; end
                else if (m_ph == P_RUN && m_sc == m_n) m_ph = P_DRAIN;
                else if (m_ph == P_DRAIN && m_dc == m_n) m_ph = P_DONE;
            end
        end
        if (CHAIN) m_cont = sink_ready;
    endtask

    task automatic check_outputs();
        chk("ap_start",    bus.ap_start,    m_ph == P_RUN);
        chk("ap_continue", bus.ap_continue, m_cont);
        chk("busy",        busy,            m_ph == P_RUN || m_ph == P_DRAIN);
        chk("finish",      finish,          m_ph == P_DONE);
        chk("timeout",     timeout,         m_to);
        chk("proto_err",   proto_err,       m_pe);
        chk("start_cnt",   start_cnt,       m_sc);
        chk("done_cnt",    done_cnt,        m_dc);
        chk("run_cycles",  run_cycles,      m_rc);
    endtask

    // One clock: emulator and model observe pre-edge values, outputs checked on the falling edge.
    task automatic step();
        @(posedge clock);
        if (bus.ap_start && bus.ap_ready) begin
            pend.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            age = 0;
        end
        if (bus.ap_done && bus.ap_continue && !spur && pend.size() > 0) void'(pend.pop_front());
        if (!reset) model_reset();
        else model_edge();
        cyc++;
        @(negedge clock);
        check_outputs();
        if (bus.ap_start) st_hi++;
        bus.ap_ready = rdy_hold ? 1'b1 :
                       (bus.ap_start && age >= rdy_dly && pend.size() < cap &&
                        $urandom_range(99, 0) < rdy_pct);
        if (bus.ap_start) age++;
        bus.ap_done = spur_req || (done_en && pend.size() > 0 && pend[0] <= cyc);
        spur = spur_req;
        spur_req = 0;
        if (sink_rand) sink_ready = ($urandom_range(3, 0) != 0);
    endtask

    task automatic set_emu(input bit hold, input int dly, input int pct, input int c,
                           input int lmin, input int lmax);
        rdy_hold = hold; rdy_dly = dly; rdy_pct = pct; cap = c; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic go(input int n);
        cfg_go = 1'b1;
        cfg_num_txn = TXN_W'(n);
        step();
        cfg_go = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int i;
        i = 0;
        while (!(finish || timeout) && i < budget) begin
            step();
            i++;
        end
        chk("run_ends_in_budget", finish || timeout, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ap_start"},    bus.ap_start, 0);
        chk({tag, "_ap_continue"}, bus.ap_continue, !CHAIN);
        chk({tag, "_busy"},        busy, 0);
        chk({tag, "_finish"},      finish, 0);
        chk({tag, "_timeout"},     timeout, 0);
        chk({tag, "_proto_err"},   proto_err, 0);
        chk({tag, "_start_cnt"},   start_cnt, 0);
        chk({tag, "_done_cnt"},    done_cnt, 0);
        chk({tag, "_run_cycles"},  run_cycles, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_reset_values(tag);
        model_reset();
        pend.delete();
        age = 0;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        model_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b1;
        step();

        // spurious done while idle, cleared by the next run
        spur_req = 1;
        step(); step();
        chk("idle_spurious_proto_err", proto_err, 1);
        set_emu(0, 0, 100, 1, 2, 2);
        go(1);
        wait_end(100);
        chk("n1_proto_err_cleared", proto_err, 0);
        chk("n1_done_cnt", done_cnt, 1);

        // N=4 non-overlapped: ready one cycle after start, done three cycles later
        set_emu(0, 1, 100, 1, 3, 3);
        go(4);
        wait_end(200);
        chk("n4_start_cnt", start_cnt, 4);
        chk("n4_done_cnt", done_cnt, 4);
        chk("n4_finish", finish, 1);
        chk("n4_proto_err", proto_err, 0);
        spur_req = 1;
        step(); step();
        chk("late_spurious_proto_err", proto_err, 1);

        // N=8 pipelined: ready held high, dones overlapping starts
        set_emu(1, 0, 100, 100, 2, 4);
        st_hi = 0;
        go(8);
        wait_end(200);
        chk("n8_start_high_cycles", st_hi, 8);
        chk("n8_done_cnt", done_cnt, 8);
        chk("n8_finish", finish, 1);

        // N=0: straight to DONE with no start
        st_hi = 0;
        go(0);
        chk("n0_finish", finish, 1);
        chk("n0_run_cycles", run_cycles, 0);
        repeat (3) step();
        chk("n0_no_start", st_hi, 0);

        // randomized runs
        sink_rand = CHAIN;
        for (int r = 0; r < 6; r++) begin
            set_emu(0, $urandom_range(2, 0), $urandom_range(100, 30), $urandom_range(4, 1), 1, 6);
            go($urandom_range(10, 1));
            wait_end(400);
            chk("rand_finish", finish, 1);
        end
        sink_rand = 0;
        sink_ready = 1'b1;
        step();

        // long run saturates run_cycles
        set_emu(0, 1, 100, 1, 3, 3);
        go(20);
        wait_end(400);
        chk("sat_run_cycles", run_cycles, RC_MAX);
        chk("sat_done_cnt", done_cnt, 20);

`ifdef AP_CTRL_CHAIN_EN
        // backpressure: dones held until ap_continue returns
        set_emu(0, 0, 100, 1, 2, 2);
        sink_ready = 1'b0;
        go(3);
        repeat (10) step();
        chk("chain_done_not_counted", done_cnt, 0);
        chk("chain_done_held", bus.ap_done, 1);
        sink_ready = 1'b1;
        wait_end(200);
        chk("chain_done_cnt", done_cnt, 3);
`endif

        // reset in the middle of a run
        set_emu(0, 0, 100, 2, 2, 5);
        go(6);
        repeat (5) step();
        async_reset("midrun");
        step();

        // hang: DUT never completes
        done_en = 0;
        set_emu(1, 0, 100, 100, 1, 1);
        go(2);
        wait_end(200);
        chk("hang_timeout", timeout, 1);
        chk("hang_busy", busy, 0);
        chk("hang_ap_start", bus.ap_start, 0);
        chk("hang_start_cnt", start_cnt, 2);
        go(3);
        step();
        chk("err_ignores_go_busy", busy, 0);
        chk("err_ignores_go_timeout", timeout, 1);
        done_en = 1;
        async_reset("err_reset");
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
